game_flow_ctl: RTL and testbench
================================

Name: game_flow_ctl

Overview:
Match-level sequencer for the air-hockey ball datapath. It gates ball motion, recentres the puck, owns both 5-bit scores, and walks the game through idle, serve, play, goal-pause and game-over. It sits between the ball physics block, which supplies goal events and consumes freeze/recenter, and the score/HUD renderers.

Parameters:
WIN_SCORE, 7, score that ends the match (1..31).
SERVE_FRAMES, 60, frame ticks the puck stays frozen at centre before play (>=1).
GOAL_PAUSE_FRAMES, 120, frame ticks of post-goal pause (>=1).
FRAME_CNT_W, 8, width of the internal frame counter; must hold max(SERVE_FRAMES, GOAL_PAUSE_FRAMES)-1.

Ports:
clk_in  in  1  system clock
rst  in  1  reset, synchronous, active-high
frame_tick  in  1  one-cycle pulse per video frame
start_btn  in  1  start level, already synchronised; the rising edge is used
goal_p1  in  1  one-cycle pulse: player 1 scored (puck in right goal)
goal_p2  in  1  one-cycle pulse: player 2 scored (puck in left goal)
ball_freeze  out  1  1 = ball datapath must hold position/speed
ball_recenter  out  1  one-cycle pulse: load puck to centre, zero speed
player_1_score  out  5  player 1 score
player_2_score  out  5  player 2 score
game_state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 GOAL, 4 OVER, 5 PAUSED
winner  out  2  0 none, 1 player 1, 2 player 2

Behaviour:
- Reset state (rst sampled high at a clk_in edge):
  - state IDLE; scores 0; winner 0; ball_freeze 1; ball_recenter 0; frame counter 0.
  - The start edge-detect register resets to 1, so a button held through reset does not start a game.
- Timing:
  - All outputs are registered.
  - An event sampled at edge t updates state, score and outputs at edge t.
  - ball_recenter is high for exactly the one cycle following a qualifying transition.
- start_rise = start_btn & ~start_d. start_d is updated every cycle.
- IDLE:
  - freeze=1.
  - start_rise -> SERVE: clear scores, winner=0, ball_recenter pulse.
- SERVE:
  - freeze=1.
  - The counter clears on entry and increments on each frame_tick.
  - A frame_tick with counter==SERVE_FRAMES-1 -> PLAY. The duration is exactly SERVE_FRAMES ticks.
- PLAY:
  - freeze=0.
  - goal_p1 alone: player_1_score+1 -> GOAL.
  - goal_p2 alone: player_2_score+1 -> GOAL.
  - Both in the same cycle: no score change -> GOAL (treated as a void round).
  - Every entry to GOAL pulses ball_recenter.
- GOAL:
  - freeze=1.
  - Counts GOAL_PAUSE_FRAMES ticks as in SERVE.
  - On expiry: if either score >= WIN_SCORE -> OVER, setting winner to the player at/over WIN_SCORE; else -> SERVE, with no further recenter pulse (puck already centred).
- OVER:
  - freeze=1; scores and winner held.
  - start_rise -> SERVE, clearing scores and winner, with a recenter pulse.
- Goal pulses are ignored in every state except PLAY.
- start_rise is ignored in SERVE, PLAY and GOAL.
- Scores never wrap. Increments stop at WIN_SCORE because OVER is reached first. The adder saturates at 31 regardless.
- A frame_tick coinciding with the state-entry cycle counts as the first tick.
- rst mid-match: immediate return to the reset state; no recenter pulse is generated by reset itself.
- State encodings 6 and 7 are illegal and recover to IDLE on the next edge.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - Adds input port pause_btn (1 bit, synchronised) with its own rising-edge detector (reset value 1).
  - Rising edge in PLAY -> PAUSED: freeze=1, goals ignored, scores held.
  - Rising edge in PAUSED -> PLAY, with no recenter.
  - Rising edges in other states are ignored.
- Undefined: no pause_btn port; encoding 5 is never produced.

Test Plan:
- Reset, then start_btn 0->1 -> one cycle later game_state=1, ball_recenter high for 1 cycle, scores 0. With SERVE_FRAMES=3, the 3rd frame_tick moves state to 2 and ball_freeze to 0.
- In PLAY, pulse goal_p1 -> player_1_score=1, state=3, recenter pulse. After GOAL_PAUSE_FRAMES ticks -> state=1 with no recenter pulse.
- WIN_SCORE=2: two goal_p2 in successive rounds -> after second pause state=4, winner=2, player_2_score=2. Start edge -> scores 0, winner 0, state 1.
- goal_p1 and goal_p2 in the same PLAY cycle -> scores unchanged, state=3. goal_p1 pulsed during SERVE or GOAL -> no score change.
- start_btn held high through reset release -> stays IDLE. Assert rst in PLAY with score 3:1 -> next cycle state 0, scores 0, freeze 1.
- With GAME_PAUSE_EN: pause edge in PLAY -> state 5, freeze 1, goal_p1 ignored. Second edge -> state 2, freeze 0, no recenter.

Source files
------------

// File: rtl/game_flow_ctl.sv
// Match-level sequencer for the air-hockey ball datapath: serve/play/goal/over flow and score ownership.
// Optional feature macro: GAME_PAUSE_EN (adds pause_btn and the PAUSED state).
module game_flow_ctl #(
    parameter int unsigned WIN_SCORE         = 7,
    parameter int unsigned SERVE_FRAMES      = 60,
    parameter int unsigned GOAL_PAUSE_FRAMES = 120,
    parameter int unsigned FRAME_CNT_W       = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       goal_p1,
    input  logic       goal_p2,
`ifdef GAME_PAUSE_EN
    input  logic       pause_btn,
`endif
    output logic       ball_freeze,
    output logic       ball_recenter,
    output logic [4:0] player_1_score,
    output logic [4:0] player_2_score,
    output logic [2:0] game_state,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_GOAL   = 3'd3,
        S_OVER   = 3'd4,
        S_PAUSED = 3'd5
    } state_t;

    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] GOAL_LAST  = FRAME_CNT_W'(GOAL_PAUSE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE    = FRAME_CNT_W'(1);
    localparam logic [4:0]             WIN_S      = 5'(WIN_SCORE);

    state_t                 r_state, w_state_nx;
    logic [FRAME_CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [4:0]             r_p1, r_p2, w_p1_nx, w_p2_nx;
    logic [4:0]             w_p1_inc, w_p2_inc;
    logic [1:0]             r_winner, w_winner_nx;
    logic                   r_freeze;
    logic                   r_recenter, w_recenter_nx;
    logic                   r_start_d, w_start_rise;

    assign w_start_rise = start_btn & ~r_start_d;
    assign w_p1_inc     = (r_p1 == 5'd31) ? r_p1 : r_p1 + 5'd1;
    assign w_p2_inc     = (r_p2 == 5'd31) ? r_p2 : r_p2 + 5'd1;

`ifdef GAME_PAUSE_EN
    logic r_pause_d, w_pause_rise;
    assign w_pause_rise = pause_btn & ~r_pause_d;

    // Resets high so a pause button held through reset is not seen as an edge.
    always_ff @(posedge clk_in) begin
        if (rst) r_pause_d <= 1'b1;
        else     r_pause_d <= pause_btn;
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_winner   <= '0;
            r_freeze   <= 1'b1;
            r_recenter <= 1'b0;
            r_start_d  <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_p1       <= w_p1_nx;
            r_p2       <= w_p2_nx;
            r_winner   <= w_winner_nx;
            r_freeze   <= (w_state_nx != S_PLAY);
            r_recenter <= w_recenter_nx;
            r_start_d  <= start_btn;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_p1_nx       = r_p1;
        w_p2_nx       = r_p2;
        w_winner_nx   = r_winner;
        w_recenter_nx = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_rise) begin
                    w_state_nx    = S_SERVE;
                    w_p1_nx       = '0;
                    w_p2_nx       = '0;
                    w_winner_nx   = '0;
                    w_recenter_nx = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (r_cnt == SERVE_LAST) w_state_nx = S_PLAY;
                    else                     w_cnt_nx   = r_cnt + CNT_ONE;
                end
            end
            S_PLAY: begin
                // Simultaneous goals void the round: GOAL without a score change.
                if (goal_p1 | goal_p2) begin
                    w_state_nx    = S_GOAL;
                    w_recenter_nx = 1'b1;
                    if (goal_p1 & ~goal_p2)      w_p1_nx = w_p1_inc;
                    else if (goal_p2 & ~goal_p1) w_p2_nx = w_p2_inc;
                end
`ifdef GAME_PAUSE_EN
                else if (w_pause_rise) begin
                    w_state_nx = S_PAUSED;
                end
`endif
            end
            S_GOAL: begin
                if (frame_tick) begin
                    if (r_cnt == GOAL_LAST) begin
                        if (r_p1 >= WIN_S) begin
                            w_state_nx  = S_OVER;
                            w_winner_nx = 2'd1;
                        end else if (r_p2 >= WIN_S) begin
                            w_state_nx  = S_OVER;
                            w_winner_nx = 2'd2;
                        end else begin
                            w_state_nx = S_SERVE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_ONE;
                    end
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (w_pause_rise) w_state_nx = S_PLAY;
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
        // Any state change restarts the frame counter so entry-cycle ticks count as the first.
        if (w_state_nx != r_state) w_cnt_nx = '0;
    end

    assign game_state     = r_state;
    assign ball_freeze    = r_freeze;
    assign ball_recenter  = r_recenter;
    assign player_1_score = r_p1;
    assign player_2_score = r_p2;
    assign winner         = r_winner;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Self-checking bench for game_flow_ctl: vector table driven through a scoreboard queue,
// plus hand sequences for serve timing and (with GAME_PAUSE_EN) pause/resume.
module tb_game_flow_ctl;

    logic       clk_in = 1'b0;
    logic       rst, frame_tick, start_btn, goal_p1, goal_p2;
    logic       ball_freeze, ball_recenter;
    logic [4:0] player_1_score, player_2_score;
    logic [2:0] game_state;
    logic [1:0] winner;
`ifdef GAME_PAUSE_EN
    logic       pause_btn;
`endif

    always #5 clk_in = ~clk_in;

    game_flow_ctl #(
        .WIN_SCORE        (2),
        .SERVE_FRAMES     (3),
        .GOAL_PAUSE_FRAMES(2),
        .FRAME_CNT_W      (4)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .start_btn     (start_btn),
        .goal_p1       (goal_p1),
        .goal_p2       (goal_p2),
`ifdef GAME_PAUSE_EN
        .pause_btn     (pause_btn),
`endif
        .ball_freeze   (ball_freeze),
        .ball_recenter (ball_recenter),
        .player_1_score(player_1_score),
        .player_2_score(player_2_score),
        .game_state    (game_state),
        .winner        (winner)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       frz;
        logic       rc;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [1:0] win;
    } exp_t;

    typedef struct {
        string name;
        logic  r, t, s, g1, g2, p;
        exp_t  e;
    } vec_t;

    vec_t  vecs[$];
    exp_t  sb_q[$];
    string sb_n[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic vec_t mk(input string name, input logic r, t, s, g1, g2, p,
                                input int st, input logic rc, input int s1, s2, w);
        vec_t v;
        v.name = name; v.r = r; v.t = t; v.s = s; v.g1 = g1; v.g2 = g2; v.p = p;
        v.e.st  = 3'(st);
        v.e.frz = (st != 2);
        v.e.rc  = rc;
        v.e.s1  = 5'(s1);
        v.e.s2  = 5'(s2);
        v.e.win = 2'(w);
        return v;
    endfunction

    task automatic check_out();
        exp_t  e, a;
        string n;
        e = sb_q.pop_front();
        n = sb_n.pop_front();
        a = '{game_state, ball_freeze, ball_recenter, player_1_score, player_2_score, winner};
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got st=%0d frz=%0b rc=%0b s1=%0d s2=%0d win=%0d, need st=%0d frz=%0b rc=%0b s1=%0d s2=%0d win=%0d",
                     n, a.st, a.frz, a.rc, a.s1, a.s2, a.win, e.st, e.frz, e.rc, e.s1, e.s2, e.win);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk_in);
        rst = v.r; frame_tick = v.t; start_btn = v.s; goal_p1 = v.g1; goal_p2 = v.g2;
`ifdef GAME_PAUSE_EN
        pause_btn = v.p;
`endif
        sb_q.push_back(v.e);
        sb_n.push_back(v.name);
        @(posedge clk_in);
        #1 check_out();
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    initial begin
        int ticks;
        bit reached;
        rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
`ifdef GAME_PAUSE_EN
        pause_btn = 1'b0;
`endif
        //                 name           r  t  s  g1 g2 p  st rc s1 s2 w
        vecs.push_back(mk("rst0",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rst1",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("start",       0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("srv_hold",    0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("srv_t1",      0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("srv_g1_ign",  0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("srv_t2",      0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("srv_t3",      0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk("play",        0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk("goal_p1",     0, 0, 1, 1, 0, 0, 3, 1, 1, 0, 0));
        vecs.push_back(mk("goal_g1_ign", 0, 0, 1, 1, 0, 0, 3, 0, 1, 0, 0));
        vecs.push_back(mk("gp_t1",       0, 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
        vecs.push_back(mk("gp_t2_serve", 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s2_t1",       0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s2_t2",       0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s2_t3",       0, 1, 1, 0, 0, 0, 2, 0, 1, 0, 0));
        vecs.push_back(mk("void_goal",   0, 0, 1, 1, 1, 0, 3, 1, 1, 0, 0));
        vecs.push_back(mk("v_t1",        0, 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
        vecs.push_back(mk("v_t2",        0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s3_t1",       0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s3_t2",       0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("s3_t3",       0, 1, 1, 0, 0, 0, 2, 0, 1, 0, 0));
        vecs.push_back(mk("goal_p2_a",   0, 0, 1, 0, 1, 0, 3, 1, 1, 1, 0));
        vecs.push_back(mk("g3_t1",       0, 1, 1, 0, 0, 0, 3, 0, 1, 1, 0));
        vecs.push_back(mk("g3_t2",       0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("s4_t1",       0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("s4_t2",       0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("s4_t3",       0, 1, 1, 0, 0, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk("goal_p2_b",   0, 0, 1, 0, 1, 0, 3, 1, 1, 2, 0));
        vecs.push_back(mk("g4_t1",       0, 1, 1, 0, 0, 0, 3, 0, 1, 2, 0));
        vecs.push_back(mk("over",        0, 1, 1, 0, 0, 0, 4, 0, 1, 2, 2));
        vecs.push_back(mk("over_rel",    0, 0, 0, 0, 0, 0, 4, 0, 1, 2, 2));
        vecs.push_back(mk("over_g1_ign", 0, 0, 0, 1, 0, 0, 4, 0, 1, 2, 2));
        vecs.push_back(mk("restart",     0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("r_t1",        0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("r_t2",        0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("r_t3",        0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk("r_goal_p1",   0, 0, 1, 1, 0, 0, 3, 1, 1, 0, 0));
        vecs.push_back(mk("r_g_t1",      0, 1, 1, 0, 0, 0, 3, 0, 1, 0, 0));
        vecs.push_back(mk("r_g_t2",      0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("r_s_t1",      0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("r_s_t2",      0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk("r_s_t3",      0, 1, 1, 0, 0, 0, 2, 0, 1, 0, 0));
        vecs.push_back(mk("r_goal_p2",   0, 0, 1, 0, 1, 0, 3, 1, 1, 1, 0));
        vecs.push_back(mk("r_g2_t1",     0, 1, 1, 0, 0, 0, 3, 0, 1, 1, 0));
        vecs.push_back(mk("r_g2_t2",     0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("r_s2_t1",     0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("r_s2_t2",     0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk("r_s2_t3",     0, 1, 1, 0, 0, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk("play_stlow",  0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk("play_st_ign", 0, 0, 1, 0, 0, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk("rst_mid",     1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rel_held",    0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle_held",   0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("idle_low",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("start2",      0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk("srv_low",     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("srv_st_ign",  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Sparse frame ticks: PLAY must arrive on exactly the third tick since entry.
        ticks   = 0;
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            @(negedge clk_in);
            frame_tick = (c % 4 == 3);
            if (frame_tick) ticks++;
            @(posedge clk_in);
            #1;
            if (game_state == 3'd2) reached = 1'b1;
            else check_val("serve_state_before_play", int'(game_state), 1);
        end
        @(negedge clk_in);
        frame_tick = 1'b0;
        check_val("serve_reach_play", int'(reached), 1);
        check_val("serve_tick_count", ticks, 3);
        check_val("play_freeze", int'(ball_freeze), 0);

`ifdef GAME_PAUSE_EN
        //                   name         r  t  s  g1 g2 p  st rc s1 s2 w
        step(mk("pause_on",          0, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0));
        step(mk("paused_g1_ign",     0, 1, 1, 1, 0, 1, 5, 0, 0, 0, 0));
        step(mk("paused_rel",        0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0));
        step(mk("pause_off",         0, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0));
`endif
        step(mk("final_goal_p1",     0, 0, 1, 1, 0, 0, 3, 1, 1, 0, 0));
        step(mk("final_goal_hold",   0, 0, 1, 0, 0, 0, 3, 0, 1, 0, 0));

        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
